// File: rtl/msdap_coeff_pkg.sv
// Shared definitions for the MSDAP coefficient store.
//   DEF_DATA_W / DEF_DEPTH / DEF_NUM_CH : default geometry (16-bit words,
//                                         512 words per bank, 2 banks)
//   coeff_state_e                       : sweep controller states
//   width_of()                          : clog2 that never returns 0, so a
//                                         single-entry select still has 1 bit
package msdap_coeff_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 512;
  localparam int DEF_NUM_CH = 2;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } coeff_state_e;

  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/coeff_bank.sv
// One coefficient bank: DEPTH x DATA_W array, synchronous write and
// registered read. A read and a write to the same address on the same edge
// return the old word (read-first).
// Ports:
//   sclk, reset_n : clock, synchronous active-low reset (read register only)
//   we, waddr, wdata : write port
//   re, raddr        : read request; rdata updates on the edge re is high
//   rdata            : registered read data, holds while re is low
module coeff_bank
  import msdap_coeff_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = width_of(DEPTH)
) (
  input  logic              sclk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // The array carries no reset so it can map onto a RAM macro.
  always_ff @(posedge sclk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge sclk) begin
    if (!reset_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/coeff_bank_memory.sv
// Coefficient store for the MSDAP filter datapath: NUM_CH banks of DEPTH
// words, a zero-fill sweep after reset or on request, per-channel
// auto-increment load pointers and a one-cycle registered read port.
// Ports:
//   sclk, reset_n         : clock, synchronous active-low reset
//   clr_req               : start a clear sweep (ignored while sweeping)
//   wr_en, wr_auto, wr_ch,
//   wr_addr, wr_data      : write request; wr_auto selects the channel pointer
//   rd_en, rd_ch, rd_addr : read request
//   rd_data, rd_valid     : read result one cycle after the request
//   wr_done / wr_err      : write accepted / rejected pulse
//   load_full             : auto pointer wrapped from DEPTH-1 to 0
//   busy, clr_done        : sweep in progress / sweep finished pulse
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | zero-fill address clr_cnt in every bank, one word per cycle
// ST_IDLE  | normal operation: reads and writes accepted
module coeff_bank_memory
  import msdap_coeff_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  parameter  int NUM_CH = DEF_NUM_CH,
  localparam int ADDR_W = width_of(DEPTH),
  localparam int CH_W   = width_of(NUM_CH)
) (
  input  logic              sclk,
  input  logic              reset_n,
  input  logic              clr_req,
  input  logic              wr_en,
  input  logic              wr_auto,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              wr_done,
  output logic              wr_err,
  output logic              load_full,
  output logic              busy,
  output logic              clr_done
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  // One bit wider than the select so NUM_CH itself is representable.
  localparam logic [CH_W:0]     CH_CNT    = (CH_W + 1)'(NUM_CH);

  coeff_state_e      state_q;
  coeff_state_e      state_d;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic [ADDR_W-1:0] wr_ptr_q [NUM_CH];

  logic              clearing;
  logic              sweep_last;
  logic              clr_start;
  logic              wr_ch_ok;
  logic              rd_ch_ok;
  logic              wr_accept;
  logic              wr_reject;
  logic              rd_accept;
  logic              ptr_wrap;
  logic [ADDR_W-1:0] ptr_sel;
  logic [NUM_CH-1:0] bank_we;
  logic [NUM_CH-1:0] bank_re;
  logic [ADDR_W-1:0] bank_waddr;
  logic [DATA_W-1:0] bank_wdata;
  logic [DATA_W-1:0] bank_rdata [NUM_CH];

  logic              rd_zero_q;
  logic [CH_W-1:0]   rd_sel_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge sclk) begin
    if (!reset_n) begin
      state_q <= ST_CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_CLEAR: if (clr_cnt_q == ADDR_LAST) state_d = ST_IDLE;
      ST_IDLE:  if (clr_req)                state_d = ST_CLEAR;
      default:                              state_d = ST_CLEAR;
    endcase
  end

  always_comb begin
    clearing   = (state_q == ST_CLEAR);
    busy       = clearing;
    sweep_last = clearing && (clr_cnt_q == ADDR_LAST);
    clr_start  = !clearing && clr_req;

    wr_ch_ok   = ({1'b0, wr_ch} < CH_CNT);
    rd_ch_ok   = ({1'b0, rd_ch} < CH_CNT);

    // A clear request in IDLE wins over a write on the same edge.
    wr_accept  = wr_en && !clearing && !clr_start && wr_ch_ok;
    wr_reject  = wr_en && !wr_accept;
    rd_accept  = rd_en && !clearing;

    ptr_sel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_ch == CH_W'(c)) ptr_sel = wr_ptr_q[c];
    end
    ptr_wrap = wr_accept && wr_auto && (ptr_sel == ADDR_LAST);

    // The sweep owns the shared write port of every bank while clearing.
    bank_waddr = clearing ? clr_cnt_q : (wr_auto ? ptr_sel : wr_addr);
    bank_wdata = clearing ? '0 : wr_data;

    bank_we = '0;
    bank_re = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      bank_we[c] = clearing || (wr_accept && (wr_ch == CH_W'(c)));
      bank_re[c] = rd_accept && rd_ch_ok && (rd_ch == CH_W'(c));
    end
  end

  // ------------------------------------------------ sweep and load pointers
  always_ff @(posedge sclk) begin
    if (!reset_n) begin
      clr_cnt_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr_q[c] <= '0;
      end
    end else begin
      // clr_cnt wraps back to 0 on the last sweep write, ready for the next.
      if (clr_start) begin
        clr_cnt_q <= '0;
      end else if (clearing) begin
        clr_cnt_q <= clr_cnt_q + 1'b1;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (clr_start) begin
          wr_ptr_q[c] <= '0;
        end else if (wr_accept && wr_auto && (wr_ch == CH_W'(c))) begin
          wr_ptr_q[c] <= wr_ptr_q[c] + 1'b1;
        end
      end
    end
  end

  // ------------------------------------------------------ output pulses
  always_ff @(posedge sclk) begin
    if (!reset_n) begin
      wr_done   <= 1'b0;
      wr_err    <= 1'b0;
      load_full <= 1'b0;
      clr_done  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_zero_q <= 1'b1;
      rd_sel_q  <= '0;
    end else begin
      wr_done   <= wr_accept;
      wr_err    <= wr_reject;
      load_full <= ptr_wrap;
      clr_done  <= sweep_last;
      rd_valid  <= rd_accept;
      if (rd_accept) begin
        rd_zero_q <= !rd_ch_ok;
        rd_sel_q  <= rd_ch;
      end
    end
  end

  // Only the selected bank's read register moves, and the select is only
  // updated on an accepted read, so rd_data holds between reads.
  always_comb begin
    rd_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!rd_zero_q && (rd_sel_q == CH_W'(c))) rd_data = bank_rdata[c];
    end
  end

  // ------------------------------------------------------------- banks
  for (genvar g = 0; g < NUM_CH; g++) begin : g_bank
    coeff_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_bank (
      .sclk    (sclk),
      .reset_n (reset_n),
      .we      (bank_we[g]),
      .waddr   (bank_waddr),
      .wdata   (bank_wdata),
      .re      (bank_re[g]),
      .raddr   (rd_addr),
      .rdata   (bank_rdata[g])
    );
  end

endmodule

// File: doc/coeff_bank_memory.md
# coeff_bank_memory

Parametrised, clocked coefficient store for the MSDAP filter datapath: NUM_CH independent banks (left/right by default), each DEPTH words of DATA_W bits. It adds a synchronous clear sweep, auto-increment load pointers and a registered read port. It sits between the serial-input loader, which writes coefficients, and the per-channel ALU controllers, which read them.

## Interface
- DATA_W, 16, coefficient word width
- DEPTH, 512, words per channel bank (power of two, ≥ 4)
- NUM_CH, 2, number of channel banks (≥ 1)
- ADDR_W, $clog2(DEPTH), derived, not overridden
- CH_W, max(1,$clog2(NUM_CH)), derived
- Clock and reset: one clock; reset is synchronous and active-low.
- sclk  in  1  system clock, all state updates on rising edge
- reset_n  in  1  synchronous active-low reset
- clr_req  in  1  start clear sweep of all banks (level sampled each cycle)
- wr_en  in  1  write request
- wr_auto  in  1  1: use the channel's internal write pointer; 0: use wr_addr
- wr_ch  in  CH_W  write channel select
- wr_addr  in  ADDR_W  explicit write address
- wr_data  in  DATA_W  write data
- rd_en  in  1  read request
- rd_ch  in  CH_W  read channel select
- rd_addr  in  ADDR_W  read address
- rd_data  out  DATA_W  read data
- rd_valid  out  1  rd_data valid pulse
- wr_done  out  1  write accepted pulse
- wr_err  out  1  write rejected pulse
- load_full  out  1  pulse: auto pointer wrapped DEPTH-1 → 0
- busy  out  1  clear sweep in progress
- clr_done  out  1  clear sweep complete pulse

## Operation
- States: CLEAR, IDLE. Reset (reset_n=0 at an edge) → CLEAR with clr_cnt=0 and all wr_ptr=0.
- Reset values: rd_data=0, rd_valid=0, wr_done=0, wr_err=0, load_full=0, clr_done=0, busy=1. Memory contents are undefined until the sweep completes.
- CLEAR: each cycle writes 0 to address clr_cnt in every bank, then increments clr_cnt. After writing DEPTH-1: go to IDLE, pulse clr_done, clear busy. Reset mid-sweep restarts the sweep from 0.
- IDLE + clr_req=1 → CLEAR. clr_cnt and all wr_ptr are zeroed. A write in the same cycle is dropped with wr_err=1. clr_req while in CLEAR is ignored.
- Write rules in IDLE:
  - wr_en=1 and wr_ch<NUM_CH: write to bank[wr_ch]; pulse wr_done.
  - Address is wr_addr when wr_auto=0, else wr_ptr[wr_ch].
  - When wr_auto=1, wr_ptr[wr_ch] increments modulo DEPTH. On the wrap it pulses load_full.
  - wr_auto=0 leaves all pointers unchanged.
- Write rejected (wr_err pulse, no memory or pointer change) when wr_ch≥NUM_CH or state is CLEAR.
- Read in IDLE: rd_en=1 returns bank[rd_ch][rd_addr]. rd_ch≥NUM_CH returns 0, still with rd_valid.
- Read in CLEAR: rd_en is ignored and rd_valid stays 0.
- Same channel/address read and write in one cycle: the read returns the pre-write value (read-first).

## Timing
- Write: request sampled at edge N. Memory is updated at edge N. wr_done/wr_err/load_full are high for the single cycle after N.
- Read latency 1: rd_en at edge N → rd_data, rd_valid valid after N for one cycle. rd_data holds its last value while rd_valid=0.
- Clear sweep takes exactly DEPTH cycles. busy falls and clr_done pulses on the edge after the last clear write. The first accepted write/read is in the cycle where busy=0.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package msdap_coeff_pkg: state enum (CLEAR, IDLE), default DATA_W/DEPTH/NUM_CH constants, clog2-based width helper.
- Sub-module coeff_bank: one synchronous-write, registered-read DEPTH×DATA_W array with read-first semantics. It is instantiated NUM_CH times by generate.
- Top holds the FSM, clr_cnt, the wr_ptr array, channel decode and the output pulse registers.

## Test plan
- Reset release, defaults → busy=1 for 512 cycles, then clr_done pulse; a read of ch1 addr 0x1FF returns 0x0000 with rd_valid one cycle later.
- Explicit write ch0 addr 5 data 0xA5A5, then read ch0 addr 5 → wr_done pulse, then rd_data=0xA5A5. Reading ch1 addr 5 returns 0x0000.
- 513 auto writes to ch1 with data = index → load_full pulse after write 512. Write 513 overwrites addr 0 with 0x0200; ch0 pointer is unaffected.
- Same-cycle write 0x1234 and read of ch0 addr 7 (old value 0x0BAD) → rd_data=0x0BAD; a next read returns 0x1234.
- clr_req together with wr_en → wr_err=1, busy=1. A write or read during the sweep gives wr_err and no rd_valid; all locations read 0 afterward.
- reset_n pulsed low at sweep cycle 200 → the sweep restarts and clr_done arrives exactly 512 cycles after release.
- wr_ch=1 with NUM_CH=1 instance → wr_err pulse and no wr_done.
